// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC read sequencer: FSM states and the
// register address map walked on every refresh.
package rtc_pkg;

    localparam int NUM_REGS_DEFAULT    = 11;
    localparam int ACK_TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP,
        ST_SOF,
        ST_STREAM
    } state_t;

    localparam logic [7:0] ADDR_TABLE [0:10] = '{
        8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
        8'h27, 8'h28, 8'h41, 8'h42, 8'h43
    };

    // Indices past the table map to address 0x00.
    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        return (idx < 4'd11) ? ADDR_TABLE[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/rtc_read_sequencer_if.sv
// RTC bus read channel plus the byte stream towards the VGA consumer.
// The master side is the sequencer, the slave side is its environment.
interface rtc_read_sequencer_if;

    logic       bus_req;
    logic [7:0] bus_addr;
    logic       bus_ack;
    logic [7:0] bus_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_idx;
    logic       frame_start;

    modport master (
        output bus_req, bus_addr, out_valid, out_data, out_idx, frame_start,
        input  bus_ack, bus_rdata, out_ready
    );

    modport slave (
        input  bus_req, bus_addr, out_valid, out_data, out_idx, frame_start,
        output bus_ack, bus_rdata, out_ready
    );

endinterface

// File: rtl/rtc_reg_bank.sv
// Capture bank for one RTC snapshot: one synchronous write port and one
// combinational read port.
module rtc_reg_bank #(
    parameter int NUM_REGS = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [NUM_REGS];

    // NOTE: this bank is cleared on reset so a snapshot never leaks across an
    // aborted frame; that forces flops, not RAM. Memories without that need
    // should stay unreset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= 8'h00;
        end else if (we && (int'(waddr) < NUM_REGS)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < NUM_REGS) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/rtc_read_sequencer.sv
// Reads NUM_REGS RTC registers into a bank on each refresh, then streams the
// snapshot to the VGA consumer behind a one-cycle frame_start pulse.
module rtc_read_sequencer
    import rtc_pkg::*;
#(
    parameter int NUM_REGS    = NUM_REGS_DEFAULT,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  refresh,
    rtc_read_sequencer_if.master  io,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam logic [3:0] LAST_IDX   = 4'(NUM_REGS - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] k;
    logic       pending;
    logic [7:0] wait_cnt;
    logic       bank_we;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;

    assign bank_we = (state == ST_REQ) && io.bus_ack;

    // out_data is registered, so the bank is read one entry ahead of k.
    // NOTE: every always_comb output gets a default first; otherwise a path
    // that skips the assignment infers a latch.
    always_comb begin
        rd_addr = 4'd0;
        if (state == ST_STREAM && k != LAST_IDX) rd_addr = k + 4'd1;
    end

    rtc_reg_bank #(.NUM_REGS(NUM_REGS)) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bank_we),
        .waddr (idx),
        .wdata (io.bus_rdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // NOTE: state is updated with non-blocking assignments only, so every
    // branch below sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx            <= 4'd0;
            k              <= 4'd0;
            pending        <= 1'b0;
            wait_cnt       <= 8'd0;
            io.bus_req     <= 1'b0;
            io.bus_addr    <= 8'h00;
            io.out_valid   <= 1'b0;
            io.out_data    <= 8'h00;
            io.out_idx     <= 4'd0;
            io.frame_start <= 1'b0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            io.frame_start <= 1'b0;
            if (refresh && state != ST_IDLE) pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (refresh || pending) begin
                        idx         <= 4'd0;
                        pending     <= 1'b0;
                        wait_cnt    <= 8'd0;
                        io.bus_req  <= 1'b1;
                        io.bus_addr <= reg_addr(4'd0);
                        busy        <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (io.bus_ack) begin
                        io.bus_req <= 1'b0;
                        state      <= ST_GAP;
                    end else begin
                        if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LIMIT) begin
                            io.bus_req  <= 1'b0;
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (idx == LAST_IDX) begin
                        io.frame_start <= 1'b1;
                        state          <= ST_SOF;
                    end else begin
                        idx         <= idx + 4'd1;
                        wait_cnt    <= 8'd0;
                        io.bus_req  <= 1'b1;
                        io.bus_addr <= reg_addr(idx + 4'd1);
                        state       <= ST_REQ;
                    end
                end
                ST_SOF: begin
                    k            <= 4'd0;
                    io.out_valid <= 1'b1;
                    io.out_data  <= rd_data;
                    io.out_idx   <= 4'd0;
                    state        <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (io.out_ready) begin
                        if (k == LAST_IDX) begin
                            k            <= 4'd0;
                            io.out_valid <= 1'b0;
                            io.out_data  <= 8'h00;
                            io.out_idx   <= 4'd0;
                            timeout_err  <= 1'b0;
                            busy         <= 1'b0;
                            state        <= ST_IDLE;
                        end else begin
                            k           <= k + 4'd1;
                            io.out_idx  <= k + 4'd1;
                            io.out_data <= rd_data;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Self-checking bench: random ack delays, read data and stream stalls, checked
// against a frame-level model of address order, captured bytes and error flag.
module tb_rtc_read_sequencer;

    localparam int N  = 11;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic refresh = 1'b0;
    logic busy;
    logic timeout_err;

    rtc_read_sequencer_if bus_if ();

    rtc_read_sequencer #(.NUM_REGS(N), .ACK_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .refresh     (refresh),
        .io          (bus_if),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] ref_addr [N] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                 8'h27, 8'h28, 8'h41, 8'h42, 8'h43};
    logic [7:0] exp_data [N];
    logic       model_terr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus_req"},     bus_if.bus_req, 0);
        check({tag, "_bus_addr"},    bus_if.bus_addr, 0);
        check({tag, "_out_valid"},   bus_if.out_valid, 0);
        check({tag, "_out_data"},    bus_if.out_data, 0);
        check({tag, "_out_idx"},     bus_if.out_idx, 0);
        check({tag, "_frame_start"}, bus_if.frame_start, 0);
        check({tag, "_busy"},        busy, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // One frame. pulse=0 means the frame is expected to start from pending.
    task automatic run_frame(input bit pulse, input bit basic, input int max_dly,
                             input int to_idx, input int rst_idx,
                             input logic [15:0] pend_mask, input bit ref_last,
                             input int bp_at, input int bp_len);
        int n;
        if (pulse) begin
            refresh = 1'b1;
            step();
            refresh = 1'b0;
        end else begin
            step();
        end
        check("start_busy", busy, 1);
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin
                check("gap_req_low", bus_if.bus_req, 0);
                step();
            end
            check("req_high", bus_if.bus_req, 1);
            check("req_addr", bus_if.bus_addr, ref_addr[i]);
            if (i == rst_idx) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                model_terr = 1'b0;
                check_reset_outputs("midrst");
                for (int j = 0; j < N; j++) check("midrst_bank", dut.u_bank.mem[j], 0);
                repeat (3) begin
                    step();
                    check("midrst_quiet_req", bus_if.bus_req, 0);
                    check("midrst_quiet_valid", bus_if.out_valid, 0);
                end
                return;
            end
            if (i == to_idx) begin
                n = 0;
                while (bus_if.bus_req === 1'b1 && n < TO + 10) begin
                    n++;
                    step();
                end
                model_terr = 1'b1;
                check("timeout_req_cycles", n, TO);
                check("timeout_err_set", timeout_err, model_terr);
                check("timeout_idle", busy, 0);
                repeat (4) begin
                    check("timeout_no_sof", bus_if.frame_start, 0);
                    check("timeout_no_valid", bus_if.out_valid, 0);
                    check("timeout_no_req", bus_if.bus_req, 0);
                    step();
                end
                return;
            end
            n = basic ? 1 : $urandom_range(0, max_dly);
            repeat (n) begin
                step();
                check("req_hold", bus_if.bus_req, 1);
                check("addr_hold", bus_if.bus_addr, ref_addr[i]);
            end
            exp_data[i] = basic ? 8'(8'h10 + i) : 8'($urandom);
            bus_if.bus_ack   = 1'b1;
            bus_if.bus_rdata = exp_data[i];
            if (pend_mask[i]) refresh = 1'b1;
            step();
            bus_if.bus_ack   = 1'b0;
            bus_if.bus_rdata = 8'($urandom);
            refresh          = 1'b0;
        end
        check("last_gap_req", bus_if.bus_req, 0);
        check("last_gap_nosof", bus_if.frame_start, 0);
        step();
        check("sof_pulse", bus_if.frame_start, 1);
        check("sof_no_valid", bus_if.out_valid, 0);
        check("sof_terr_sticky", timeout_err, model_terr);
        step();
        check("sof_once", bus_if.frame_start, 0);
        for (int k = 0; k < N; k++) begin
            check("stream_valid", bus_if.out_valid, 1);
            check("stream_idx", bus_if.out_idx, k);
            check("stream_data", bus_if.out_data, exp_data[k]);
            n = (k == bp_at) ? bp_len : $urandom_range(0, 2);
            bus_if.out_ready = 1'b0;
            repeat (n) begin
                step();
                check("bp_valid", bus_if.out_valid, 1);
                check("bp_data", bus_if.out_data, exp_data[k]);
                check("bp_idx", bus_if.out_idx, k);
            end
            bus_if.out_ready = 1'b1;
            if (k == N - 1 && ref_last) refresh = 1'b1;
            step();
            bus_if.out_ready = 1'b0;
            refresh          = 1'b0;
        end
        model_terr = 1'b0;
        check("end_valid", bus_if.out_valid, 0);
        check("end_busy", busy, 0);
        check("end_terr", timeout_err, model_terr);
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        repeat (cycles) begin
            step();
            check({tag, "_req"}, bus_if.bus_req, 0);
            check({tag, "_busy"}, busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 8'h00;
        bus_if.out_ready = 1'b0;

        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        check_reset_outputs("post_reset");

        // Acks and data on the bus while idle must be ignored.
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 8'hA5;
        expect_idle("stray_ack", 3);
        bus_if.bus_ack = 1'b0;

        run_frame(1, 1, 0, -1, -1, 16'h0, 0, -1, 0);
        run_frame(1, 0, 0, -1, -1, 16'h0, 0, -1, 0);
        run_frame(1, 0, 3, -1, -1, 16'h0, 0, 4, 5);
        repeat (3) run_frame(1, 0, 4, -1, -1, 16'h0, 0, -1, 0);

        run_frame(1, 0, 2, 3, -1, 16'h0, 0, -1, 0);
        run_frame(1, 0, 2, -1, -1, 16'h0, 0, -1, 0);

        // Two refreshes during a frame collapse into one follow-on frame.
        run_frame(1, 0, 2, -1, -1, 16'h0024, 0, -1, 0);
        run_frame(0, 0, 2, -1, -1, 16'h0, 0, -1, 0);
        expect_idle("after_pending", 5);

        // A refresh on the return-to-idle edge is kept as pending.
        run_frame(1, 0, 1, -1, -1, 16'h0, 1, -1, 0);
        run_frame(0, 0, 1, -1, -1, 16'h0, 0, -1, 0);
        expect_idle("after_last_refresh", 3);

        run_frame(1, 0, 2, -1, 6, 16'h0, 0, -1, 0);
        run_frame(1, 0, 2, -1, -1, 16'h0, 0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtc_read_sequencer.md
RTC_READ_SEQUENCER -- requirements
Module: rtc_read_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 11: number of RTC registers read per refresh.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles to wait for bus_ack.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port refresh, input, 1: one-cycle request to start a read frame.
REQ-006 SHALL have port bus_req, output, 1: read request to the RTC bus interface.
REQ-007 SHALL have port bus_addr, output, 8: RTC register address for the current read.
REQ-008 SHALL have port bus_ack, input, 1: read complete; bus_rdata is valid in the same cycle.
REQ-009 SHALL have port bus_rdata, input, 8: read data.
REQ-010 SHALL have port out_valid, output, 1: out_data and out_idx are valid.
REQ-011 SHALL have port out_ready, input, 1: the VGA consumer accepts the byte.
REQ-012 SHALL have port out_data, output, 8: captured register byte.
REQ-013 SHALL have port out_idx, output, 4: index of out_data, 0..NUM_REGS-1.
REQ-014 SHALL have port frame_start, output, 1: one-cycle pulse that precedes byte 0 of each stream.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port timeout_err, output, 1: sticky error flag; cleared only by rst_n or by the next frame that completes.

Function
REQ-017 SHALL implement states IDLE, REQ, GAP, SOF and STREAM.
REQ-018 IDLE: on refresh=1 or pending=1, SHALL set idx=0, clear pending, and go to REQ.
REQ-019 REQ: bus_req=1 and bus_addr=ADDR_TABLE[idx]; both SHALL stay stable until bus_ack=1 is sampled.
REQ-020 REQ with bus_ack=1: SHALL write bank[idx]<=bus_rdata on that edge and go to GAP; bus_req SHALL be 0 in GAP.
REQ-021 GAP lasts exactly one cycle: if idx==NUM_REGS-1, go to SOF; otherwise idx<=idx+1 and go to REQ.
REQ-022 Timeout: when the wait counter in REQ reaches ACK_TIMEOUT with no ack, SHALL set timeout_err=1 and go to IDLE; bank entries already captured are kept, and no stream is produced.
REQ-023 The wait counter SHALL be 8 bits, cleared on every entry to REQ, and saturating.
REQ-024 SOF: frame_start=1 for exactly one cycle, then go to STREAM with k=0.
REQ-025 STREAM: out_valid=1, out_data=bank[k], out_idx=k. When out_valid&out_ready, k increments. Accepting k==NUM_REGS-1 SHALL clear timeout_err and return to IDLE.
REQ-026 With out_ready=0, out_data and out_idx SHALL be held stable; there is no timeout in STREAM.
REQ-027 Latency SHALL be: refresh at edge N gives bus_req=1 in cycle N+1. With zero-wait acks, the frame is 2*NUM_REGS cycles of reads, plus 1 cycle SOF, plus NUM_REGS stream cycles.
REQ-028 refresh while busy=1 SHALL set a single-deep pending flag. Further refreshes are dropped. Pending is served on the cycle after IDLE is re-entered.
REQ-029 refresh and return-to-IDLE on the same edge SHALL set pending, not be lost.
REQ-030 bus_ack outside REQ SHALL be ignored.
REQ-031 Index counters SHALL wrap only through explicit reset to 0, never by arithmetic overflow.

Reset
REQ-032 With rst_n=0 at a clock edge, the block SHALL be in state IDLE with idx=0, k=0, pending=0 and all bank entries=0x00.
REQ-033 Under reset, outputs SHALL be bus_req=0, bus_addr=0x00, out_valid=0, out_data=0x00, out_idx=0, frame_start=0, busy=0 and timeout_err=0.
REQ-034 Reset mid-frame SHALL abort the frame on that edge, with no further bus_req or out_valid.

Structure
REQ-035 Shared package rtc_pkg SHALL hold the state enum, NUM_REGS_DEFAULT and ADDR_TABLE[0..10] = 0x21,0x22,0x23,0x24,0x25,0x26,0x27,0x28,0x41,0x42,0x43.
REQ-036 The register bank SHALL be one sub-module, rtc_reg_bank: an NUM_REGS x 8 array with one synchronous write port and one combinational read port.

Verification
REQ-037 Basic frame: refresh with acks one cycle after each bus_req and bus_rdata=0x10+idx, out_ready=1 -> 11 reads to addresses 0x21..0x43, frame_start once, then out_data 0x10..0x1A with out_idx 0..10.
REQ-038 Backpressure: out_ready low for 5 cycles at k=4 -> out_data=0x14 held stable for 5 cycles; the stream then completes in order.
REQ-039 Timeout: no ack at idx=3 -> timeout_err=1 after 255 cycles, state IDLE, no frame_start; the next good frame clears timeout_err.
REQ-040 Pending: two refreshes during a frame -> exactly one extra frame starts the cycle after IDLE.
REQ-041 Reset at idx=6 -> bus_req=0 on the next cycle, bank all 0x00, busy=0.
